bubble_sorter: RTL
==================

BUBBLE_SORTER -- requirements
Module: bubble_sorter

Interface
REQ-001 Parameter STEP_CYCLES, default 50000000: clock cycles per compare/swap step (sets visualisation pace); legal range 1 and above.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 num_in  input  4  unsigned digit to enter.
REQ-005 load  input  1  single-cycle pulse; shifts num_in into the array.
REQ-006 start  input  1  single-cycle pulse; begins sorting the array.
REQ-007 sorted_nums  output  4 x 4 (unpacked [0:3])  live array contents; indexed as the downstream display expects.
REQ-008 sorting_done  output  1  high while the array holds a completed sort.
REQ-009 busy  output  1  high while sorting.
REQ-010 cmp_idx  output  2  index j of the pair (j, j+1) under comparison; 0 when not busy.

Function
REQ-011 FSM states SHALL be IDLE, SORT and DONE; busy = (state==SORT) and sorting_done = (state==DONE), both registered.
REQ-012 Load in IDLE or DONE: arr[3]<=arr[2], arr[2]<=arr[1], arr[1]<=arr[0], arr[0]<=num_in; state<=IDLE (DONE clears next cycle).
REQ-013 Load during SORT SHALL be ignored.
REQ-014 Start in IDLE or DONE with load low: state<=SORT, pass<=0, j<=0, step counter<=0, swapped flag<=0.
REQ-015 Start during SORT is ignored; start and load in the same cycle: load wins, start ignored.
REQ-016 In SORT the step counter counts 0..STEP_CYCLES-1; the step executes on the edge where counter==STEP_CYCLES-1; the counter then wraps to 0.
REQ-017 Step: if arr[j] > arr[j+1] (unsigned 4-bit compare), swap them and set the swapped flag; equal values are never swapped.
REQ-018 Pass p covers j = 0..2-p; after the last j of a pass, j<=0 and pass<=p+1, and the swapped flag clears.
REQ-019 At the last step of a pass, state SHALL go to DONE on the same edge if no swap occurred in that pass (including that step) or p==2.
REQ-020 Final result: sorted_nums[0] <= sorted_nums[1] <= sorted_nums[2] <= sorted_nums[3].
REQ-021 Array updates and the SORT->DONE transition are on the same edge, so sorting_done rises with final data already valid.
REQ-022 Cycle count: sorting_done rises exactly N*STEP_CYCLES edges after the start edge, where N = number of steps executed (3 <= N <= 6).
REQ-023 In DONE, the array and outputs hold until load, start or rst.
REQ-024 In SORT, cmp_idx = j; sorted_nums shows intermediate array contents after every step.

Reset
REQ-025 rst has priority over load and start; on rst: arr[0..3]=0, state=IDLE, busy=0, sorting_done=0, cmp_idx=0, pass=0, j=0, counter=0, swapped=0.
REQ-026 rst asserted mid-SORT aborts the sort; the array clears to 0 on the next edge and no done pulse is produced.

Verification (STEP_CYCLES=4)
REQ-027 Load 3,1,2,0 then start -> arr before start [0]=0,[1]=2,[2]=1,[3]=3; one swap at j=1; 5 steps; sorting_done at start+20 cycles; result 0,1,2,3.
REQ-028 Load 0,1,2,3 (array 3,2,1,0) then start -> swap on every step, 6 steps; done at start+24; result 0,1,2,3.
REQ-029 Load 3,2,1,0 (already sorted) then start -> 3 steps, no swaps; done at start+12; array unchanged.
REQ-030 Load 5,5,2,5 then start -> equal values never swapped; result 2,5,5,5; cmp_idx sequence 0,1,2,0,1.
REQ-031 Load pulses and a second start during SORT -> ignored; the array matches the uninterrupted run; load in DONE clears sorting_done on the next cycle.
REQ-032 rst at start+9 of the REQ-028 run -> next cycle all outputs 0, state IDLE; a subsequent start sorts 0,0,0,0 in 3 steps.

Source files
------------

// File: rtl/bubble_sorter.sv
// Four-entry, 4-bit bubble sorter paced one compare/swap step per STEP_CYCLES
// clocks, so the intermediate array can be shown on a display as it sorts.
module bubble_sorter #(
    parameter int unsigned STEP_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] num_in,
    input  logic       load,
    input  logic       start,
    output logic [3:0] sorted_nums [0:3],
    output logic       sorting_done,
    output logic       busy,
    output logic [1:0] cmp_idx
);

    localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       pass;
    logic [1:0]       j;
    logic [CNT_W-1:0] cnt;
    logic             swapped;

    logic [1:0]       j_nxt;
    logic [3:0]       a_lo;
    logic [3:0]       a_hi;
    logic             do_swap;
    logic             any_swap;
    logic             last_j;
    logic             finish;

    // j is forced to 0 whenever the FSM leaves SORT, so it doubles as the index output
    assign cmp_idx = j;

    // Compare/decision terms for the pair (j, j+1) of the current pass
    always_comb begin
        j_nxt    = j + 2'd1;
        a_lo     = sorted_nums[j];
        a_hi     = sorted_nums[j_nxt];
        do_swap  = a_lo > a_hi;
        any_swap = swapped | do_swap;
        last_j   = (j == (2'd2 - pass));
        finish   = last_j && (!any_swap || (pass == 2'd2));
    end

    // Control FSM, step pacing counter and array storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                sorted_nums[i] <= 4'd0;
            end
            state        <= IDLE;
            busy         <= 1'b0;
            sorting_done <= 1'b0;
            pass         <= 2'd0;
            j            <= 2'd0;
            cnt          <= '0;
            swapped      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load) begin
                        sorted_nums[3] <= sorted_nums[2];
                        sorted_nums[2] <= sorted_nums[1];
                        sorted_nums[1] <= sorted_nums[0];
                        sorted_nums[0] <= num_in;
                        state          <= IDLE;
                        busy           <= 1'b0;
                        sorting_done   <= 1'b0;
                    end else if (start) begin
                        state        <= SORT;
                        busy         <= 1'b1;
                        sorting_done <= 1'b0;
                        pass         <= 2'd0;
                        j            <= 2'd0;
                        cnt          <= '0;
                        swapped      <= 1'b0;
                    end
                end
                SORT: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (do_swap) begin
                            sorted_nums[j]     <= a_hi;
                            sorted_nums[j_nxt] <= a_lo;
                        end
                        if (last_j) begin
                            j       <= 2'd0;
                            pass    <= pass + 2'd1;
                            swapped <= 1'b0;
                            if (finish) begin
                                state        <= DONE;
                                busy         <= 1'b0;
                                sorting_done <= 1'b1;
                            end
                        end else begin
                            j       <= j_nxt;
                            swapped <= any_swap;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    sorting_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
